fixed_point_accumulator: RTL and testbench
==========================================

Name: fixed_point_accumulator

Overview:
- Streaming signed accumulator that consumes the per-cycle sums produced by the 32-bit fixed-point adder path.
- Sums a programmed number of Q16.16 samples with signed saturation and returns a single result through a valid/ready handshake.
- Sits downstream of the 32-bit adder, ahead of the result formatting and storage stages.

Parameters:
- WIDTH, 32, data width of the samples and the result (two's complement).
- FRAC, 16, fractional bits. Informational only; the arithmetic is format-agnostic.
- LEN_W, 8, width of the sample-count field.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- len  input  LEN_W  number of samples in the frame; sampled when start is accepted.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  accumulator accepts in_data.
- in_data  input  WIDTH  signed sample.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  signed saturated sum (registered).
- overflow  output  1  set if any add in the frame saturated; valid while out_valid is high.
- busy  output  1  high in ACCUM and DONE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clock edge, including mid-frame):
  - state goes to IDLE.
  - accumulator, count, out_data, overflow, in_ready, out_valid and busy are all cleared to 0.
  - any partially accumulated frame is discarded.
- States: IDLE, ACCUM, DONE. All outputs are registered or decoded from the state.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with len>0: latch len, clear accumulator, count, out_data and overflow, then go to ACCUM.
  - start=1 with len=0: clear accumulator and overflow, then go to DONE (result 0).
- ACCUM:
  - in_ready=1.
  - A transfer occurs when in_valid and in_ready are both high. On a transfer:
    - acc <= sat(acc + in_data); count increments.
    - if count equals len-1 before the increment, go to DONE.
  - No transfer means no change. start is ignored.
- DONE:
  - out_valid=1, out_data=acc, in_ready=0.
  - out_valid and out_data are held stable until out_ready=1, then go to IDLE.
  - start is ignored while in DONE, including a start in the same cycle as the out_ready handshake. The new frame needs start in IDLE.
- Latency: out_valid rises on the cycle after the clock edge that accepts the last sample. There are no bubbles between accepted samples; one sample is accepted per cycle at full rate.
- Arithmetic:
  - Internal sum is WIDTH+1 bits, sign-extended.
  - If the sum exceeds 2^(WIDTH-1)-1, clamp to 0x7FFFFFFF. If it is below -2^(WIDTH-1), clamp to 0x80000000.
  - A clamp sets overflow, which stays set (sticky) until the next accepted start or reset.
  - Accumulation continues from the clamped value; there is no wrap-around.
- Count width: len up to 2^LEN_W-1 is supported. The count register never wraps within a frame.

Test Plan:
1. Basic sum: start, len=4, samples 0x00010000, 0x00020000, 0x00030000, 0x00040000 on back-to-back cycles -> out_valid rises the cycle after the 4th accept; out_data=0x000A0000; overflow=0.
2. Saturation, both signs:
   - len=2, samples 0x7FFFFFFF then 0x00000001 -> out_data=0x7FFFFFFF, overflow=1.
   - len=2, samples 0x80000000 then 0xFFFFFFFF -> out_data=0x80000000, overflow=1.
3. Post-clamp recovery: len=3, samples 0x7FFFFFF0, 0x00000100, 0xFFFFFF00 -> out_data=0x7FFFFEFF, overflow=1 (no wrap, sticky flag).
4. Backpressure:
   - len=3 with in_valid low for 2 cycles between samples -> in_ready stays 1 and the count does not advance on idle cycles.
   - Hold out_ready=0 for 5 cycles in DONE while pulsing start -> out_data stable, in_ready=0, start ignored.
   - Raise out_ready -> return to IDLE next cycle.
5. Empty frame: start with len=0 -> out_valid=1 on the next cycle, out_data=0x00000000, overflow=0; no input is consumed.
6. Reset mid-frame: len=4, accept 2 samples, assert rst for 1 cycle -> next cycle all outputs 0, state IDLE. A new start with len=1 and sample 0x00050000 -> out_data=0x00050000.

Source files
------------

// File: rtl/fixed_point_accumulator.sv
// rtl/fixed_point_accumulator.sv - streaming signed saturating accumulator for Q16.16 frames
module fixed_point_accumulator #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overflow,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    // The fraction position only matters to the surrounding stages; reject nonsense values early.
    if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
        $error("FRAC must lie in [0, WIDTH)");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_q;

    logic [WIDTH:0]   sum_ext;
    logic             sat_pos;
    logic             sat_neg;
    logic [WIDTH-1:0] sum_sat;
    logic             xfer;
    logic             last;

    // Handshake flags follow directly from the state so they never lag a transition.
    assign in_ready  = (state == S_ACCUM);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_ACCUM) || (state == S_DONE);

    // One extra bit of headroom makes the overflow test a simple top-two-bits compare.
    always_comb begin
        sum_ext = {acc[WIDTH-1], acc} + {in_data[WIDTH-1], in_data};
        sat_pos = ~sum_ext[WIDTH] &  sum_ext[WIDTH-1];
        sat_neg =  sum_ext[WIDTH] & ~sum_ext[WIDTH-1];
        if (sat_pos) begin
            sum_sat = SAT_MAX;
        end else if (sat_neg) begin
            sum_sat = SAT_MIN;
        end else begin
            sum_sat = sum_ext[WIDTH-1:0];
        end
        xfer = in_valid && (state == S_ACCUM);
        last = (count == (len_q - LEN_ONE));
    end

    // Frame control, accumulation and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            acc      <= '0;
            count    <= '0;
            len_q    <= '0;
            out_data <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        count    <= '0;
                        out_data <= '0;
                        overflow <= 1'b0;
                        len_q    <= len;
                        state    <= (len == '0) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (xfer) begin
                        acc <= sum_sat;
                        if (sat_pos || sat_neg) begin
                            overflow <= 1'b1;
                        end
                        if (last) begin
                            out_data <= sum_sat;
                            state    <= S_DONE;
                        end else begin
                            count <= count + LEN_ONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// tb/tb_fixed_point_accumulator.sv - scoreboard bench for fixed_point_accumulator
module tb_fixed_point_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        overflow;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    logic [31:0] smp[$];
    logic [31:0] sb_d[$];
    logic        sb_o[$];

    fixed_point_accumulator #(.WIDTH(32), .FRAC(16), .LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer sum of the frame, clamped to the 32-bit signed range after each add.
    task automatic model(input int n, output logic [31:0] d, output logic ov);
        longint a;
        a  = 0;
        ov = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = a + longint'($signed(smp[i]));
            if (a > 64'sd2147483647) begin
                a  = 64'sd2147483647;
                ov = 1'b1;
            end else if (a < -64'sd2147483648) begin
                a  = -64'sd2147483648;
                ov = 1'b1;
            end
        end
        d = a[31:0];
    endtask

    // Monitor: every accepted result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_d.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL sb_underflow: got result 0x%08h expected no result", out_data);
            end else begin
                check("result_data", out_data, sb_d.pop_front());
                check("result_overflow", {31'd0, overflow}, {31'd0, sb_o.pop_front()});
            end
        end
    end

    // Entered and left at posedge+1 with the DUT in IDLE.
    task automatic run_frame(input int n, input int max_gap, input int hold, input bit pulse);
        logic [31:0] ed;
        logic        eo;
        int          gaps;
        model(n, ed, eo);
        sb_d.push_back(ed);
        sb_o.push_back(eo);
        start = 1'b1;
        len   = 8'(n);
        @(posedge clk); #1;
        start = 1'b0;
        len   = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                @(negedge clk);
                check("in_ready_gap", {31'd0, in_ready}, 32'd1);
                check("busy_gap", {31'd0, busy}, 32'd1);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = smp[i];
            @(negedge clk);
            check("in_ready_accum", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_out_valid", {31'd0, out_valid}, 32'd1);
        check("done_in_ready", {31'd0, in_ready}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        for (int h = 0; h < hold; h++) begin
            start = pulse && (h % 2 == 0);
            len   = 8'd3;
            @(negedge clk);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_out_data", out_data, ed);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        start     = pulse;
        len       = 8'd3;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_sample();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'h7FFF_FFFF - 32'($urandom_range(0, 255));
            2:       return 32'h8000_0000 + 32'($urandom_range(0, 255));
            default: return 32'($urandom_range(0, 65535)) - 32'd32768;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        smp = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
        run_frame(4, 0, 0, 1'b0);
        smp = '{32'h7FFF_FFFF, 32'h0000_0001};
        run_frame(2, 0, 1, 1'b0);
        smp = '{32'h8000_0000, 32'hFFFF_FFFF};
        run_frame(2, 0, 1, 1'b0);
        smp = '{32'h7FFF_FFF0, 32'h0000_0100, 32'hFFFF_FF00};
        run_frame(3, 0, 0, 1'b0);
        smp = '{32'h0000_1000, 32'h0000_2000, 32'hFFFF_F000};
        run_frame(3, 2, 5, 1'b1);
        smp.delete();
        run_frame(0, 0, 2, 1'b1);

        smp = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
        start = 1'b1;
        len   = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = smp[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        smp = '{32'h0005_0000};
        run_frame(1, 0, 0, 1'b0);

        smp.delete();
        for (int i = 0; i < 255; i++) smp.push_back(32'($urandom_range(0, 65535)));
        run_frame(255, 0, 0, 1'b0);

        for (int f = 0; f < 30; f++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
            smp.delete();
            for (int i = 0; i < n; i++) smp.push_back(rand_sample());
            run_frame(n, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb_d.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
